// File: rtl/clk_div_ctrl_if.sv
//==============================================================================
//  Module      : clk_div_ctrl_if
//  Description : Control/status bundle for the clk_div_ctrl programmable clock
//                divider. It carries the run enable, the ratio request
//                handshake, the error clear and all divider status outputs.
//  Ports       : (signals)
//                en        - run enable for the divider
//                cfg_valid - new ratio request
//                cfg_div   - requested ratio N
//                cfg_ready - request accepted when cfg_valid & cfg_ready
//                err_clr   - clears the sticky error flag
//                clk_en    - one-cycle pulse on last cycle of each period
//                clk_div   - divided clock (registered)
//                cur_div   - active ratio
//                busy      - ratio change pending
//                err       - sticky illegal-request flag
//  Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

interface clk_div_ctrl_if #(
   parameter int DIV_W = 5
);
   logic             en;
   logic             cfg_valid;
   logic [DIV_W-1:0] cfg_div;
   logic             cfg_ready;
   logic             err_clr;
   logic             clk_en;
   logic             clk_div;
   logic [DIV_W-1:0] cur_div;
   logic             busy;
   logic             err;

   // Divider side
   modport slave (
      input  en, cfg_valid, cfg_div, err_clr,
      output cfg_ready, clk_en, clk_div, cur_div, busy, err
   );

   // Controller side
   modport master (
      output en, cfg_valid, cfg_div, err_clr,
      input  cfg_ready, clk_en, clk_div, cur_div, busy, err
   );
endinterface

`default_nettype wire

// File: rtl/clk_div_ctrl.sv
//==============================================================================
//  Module      : clk_div_ctrl
//  Description : Programmable integer clock divider producing a registered
//                divided clock (clk_div) and a matching clock-enable pulse
//                (clk_en). The ratio may be changed on the fly; changes take
//                effect only on period boundaries so no high or low phase of
//                clk_div is ever truncated.
//  Ports       : clk  - sole clock, rising edge
//                rst  - asynchronous, active-low reset
//                bus  - clk_div_ctrl_if.slave control/status bundle
//  Parameters  : DIV_W       - width of the divide ratio
//                DEFAULT_DIV - ratio loaded at reset (1..2^DIV_W-1)
//  Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module clk_div_ctrl #(
   parameter int DIV_W       = 5,
   parameter int DEFAULT_DIV = 3
) (
   input  wire logic       clk,
   input  wire logic       rst,
   clk_div_ctrl_if.slave   bus
);

   localparam logic [DIV_W-1:0] DEF_DIV_C = DIV_W'(DEFAULT_DIV);
   localparam logic [DIV_W-1:0] ONE_C     = DIV_W'(1);
   localparam logic [DIV_W-1:0] ZERO_C    = '0;

   typedef enum logic [1:0] {
      ST_STOP = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2
   } state_t;

   state_t           state_q,    state_d;
   logic [DIV_W-1:0] cnt_q,      cnt_d;
   logic [DIV_W-1:0] cur_div_q,  cur_div_d;
   logic [DIV_W-1:0] pend_div_q, pend_div_d;
   logic             err_q,      err_d;
   logic             clk_div_q,  clk_div_d;
   logic             clk_en_q,   clk_en_d;
   logic             cfg_ready_q, cfg_ready_d;
   logic             busy_q,     busy_d;

   logic             accept;
   logic             legal;
   logic             last;
   logic             running_d;
   logic [DIV_W:0]   half_d;

   // Handshake is judged against the registered ready so no input reaches
   // any output combinationally.
   assign accept = bus.cfg_valid & cfg_ready_q;
   assign legal  = (bus.cfg_div != ZERO_C);
   assign last   = (cnt_q == (cur_div_q - ONE_C));

   //---------------------------------------------------------------------------
   // Next-state / next-output logic
   //---------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cur_div_d  = cur_div_q;
      pend_div_d = pend_div_q;
      err_d      = err_q;

      // A new illegal accept wins over a simultaneous clear.
      if (bus.err_clr) begin
         err_d = 1'b0;
      end
      if (accept && !legal) begin
         err_d = 1'b1;
      end

      case (state_q)
         ST_STOP: begin
            cnt_d = ZERO_C;
            if (accept && legal) begin
               cur_div_d = bus.cfg_div;
            end
            if (bus.en) begin
               state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            if (!bus.en) begin
               // Stopping is a period boundary of its own, so a request
               // arriving on the same edge is applied directly.
               state_d = ST_STOP;
               cnt_d   = ZERO_C;
               if (accept && legal) begin
                  cur_div_d = bus.cfg_div;
               end
            end else if (accept && legal) begin
               if (last) begin
                  // Already at the boundary: apply without going through PEND.
                  cur_div_d = bus.cfg_div;
                  cnt_d     = ZERO_C;
               end else begin
                  pend_div_d = bus.cfg_div;
                  state_d    = ST_PEND;
                  cnt_d      = cnt_q + ONE_C;
               end
            end else begin
               cnt_d = last ? ZERO_C : (cnt_q + ONE_C);
            end
         end

         ST_PEND: begin
            if (!bus.en) begin
               state_d   = ST_STOP;
               cnt_d     = ZERO_C;
               cur_div_d = pend_div_q;
            end else if (last) begin
               state_d   = ST_RUN;
               cnt_d     = ZERO_C;
               cur_div_d = pend_div_q;
            end else begin
               cnt_d = cnt_q + ONE_C;
            end
         end

         default: begin
            state_d = ST_STOP;
            cnt_d   = ZERO_C;
         end
      endcase

      // Outputs are precomputed from next-state values so that each output
      // flop lines up with the state it describes.
      running_d   = (state_d != ST_STOP);
      half_d      = ({1'b0, cur_div_d} + (DIV_W+1)'(1)) >> 1;   // ceil(N/2)
      clk_div_d   = running_d && ({1'b0, cnt_d} < half_d);
      clk_en_d    = running_d && (cnt_d == (cur_div_d - ONE_C));
      cfg_ready_d = (state_d != ST_PEND);
      busy_d      = (state_d == ST_PEND);
   end

   //---------------------------------------------------------------------------
   // State and output registers
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_STOP;
         cnt_q       <= ZERO_C;
         cur_div_q   <= DEF_DIV_C;
         pend_div_q  <= DEF_DIV_C;
         err_q       <= 1'b0;
         clk_div_q   <= 1'b0;
         clk_en_q    <= 1'b0;
         cfg_ready_q <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cur_div_q   <= cur_div_d;
         pend_div_q  <= pend_div_d;
         err_q       <= err_d;
         clk_div_q   <= clk_div_d;
         clk_en_q    <= clk_en_d;
         cfg_ready_q <= cfg_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.clk_div   = clk_div_q;
   assign bus.clk_en    = clk_en_q;
   assign bus.cur_div   = cur_div_q;
   assign bus.busy      = busy_q;
   assign bus.err       = err_q;
   assign bus.cfg_ready = cfg_ready_q;

endmodule

`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
//==============================================================================
//  Module      : tb_clk_div_ctrl
//  Description : Directed self-checking bench for clk_div_ctrl.
//  Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_clk_div_ctrl;

   localparam int DIV_W = 5;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   clk_div_ctrl_if #(.DIV_W(DIV_W)) bus ();

   clk_div_ctrl #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   // Advance one clock; outputs are sampled and inputs changed 1ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.en = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_div = '0; bus.err_clr = 1'b0;
      tick(); tick();
      n_tests++; if (bus.clk_div !== 1'b0)   begin n_fail++; $display("FAIL reset_clk_div: got %b expected 0", bus.clk_div); end
      n_tests++; if (bus.clk_en !== 1'b0)    begin n_fail++; $display("FAIL reset_clk_en: got %b expected 0", bus.clk_en); end
      n_tests++; if (bus.cur_div !== 5'd3)   begin n_fail++; $display("FAIL reset_cur_div: got %0d expected 3", bus.cur_div); end
      n_tests++; if (bus.busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      n_tests++; if (bus.err !== 1'b0)       begin n_fail++; $display("FAIL reset_err: got %b expected 0", bus.err); end
      n_tests++; if (bus.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cfg_ready: got %b expected 1", bus.cfg_ready); end
      rst = 1'b1;
      // No divided clock while en stays low.
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++; if (bus.clk_div !== 1'b0) begin n_fail++; $display("FAIL idle_clk_div cycle %0d: got %b expected 0", i, bus.clk_div); end
         n_tests++; if (bus.clk_en !== 1'b0)  begin n_fail++; $display("FAIL idle_clk_en cycle %0d: got %b expected 0", i, bus.clk_en); end
      end
   endtask

   task automatic test_default_run();
      logic exp_div, exp_en;
      bus.en = 1'b1;
      tick();
      for (int i = 0; i < 6; i++) begin
         exp_div = ((i % 3) != 2);
         exp_en  = ((i % 3) == 2);
         n_tests++; if (bus.clk_div !== exp_div) begin n_fail++; $display("FAIL div3_clk_div cycle %0d: got %b expected %b", i, bus.clk_div, exp_div); end
         n_tests++; if (bus.clk_en !== exp_en)   begin n_fail++; $display("FAIL div3_clk_en cycle %0d: got %b expected %b", i, bus.clk_en, exp_en); end
         tick();
      end
      n_tests++; if (bus.cur_div !== 5'd3) begin n_fail++; $display("FAIL div3_cur_div: got %0d expected 3", bus.cur_div); end
   endtask

   // Request at the last count of a period applies immediately.
   task automatic test_direct_change();
      logic exp_div, exp_en;
      tick(); tick();                         // cnt = 2 (last of N=3)
      n_tests++; if (bus.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL direct_ready: got %b expected 1", bus.cfg_ready); end
      bus.cfg_valid = 1'b1; bus.cfg_div = 5'd5;
      tick();
      bus.cfg_valid = 1'b0;
      n_tests++; if (bus.cur_div !== 5'd5) begin n_fail++; $display("FAIL direct_cur_div: got %0d expected 5", bus.cur_div); end
      for (int i = 0; i < 5; i++) begin
         exp_div = (i < 3);
         exp_en  = (i == 4);
         n_tests++; if (bus.busy !== 1'b0)       begin n_fail++; $display("FAIL direct_busy cycle %0d: got %b expected 0", i, bus.busy); end
         n_tests++; if (bus.clk_div !== exp_div) begin n_fail++; $display("FAIL div5_clk_div cycle %0d: got %b expected %b", i, bus.clk_div, exp_div); end
         n_tests++; if (bus.clk_en !== exp_en)   begin n_fail++; $display("FAIL div5_clk_en cycle %0d: got %b expected %b", i, bus.clk_en, exp_en); end
         tick();
      end
      // Back to N=3 the same way, from cnt = 4.
      repeat (4) tick();
      bus.cfg_valid = 1'b1; bus.cfg_div = 5'd3;
      tick();
      bus.cfg_valid = 1'b0;
      n_tests++; if (bus.cur_div !== 5'd3) begin n_fail++; $display("FAIL direct_back_cur_div: got %0d expected 3", bus.cur_div); end
   endtask

   // Request mid-period goes through PEND and applies at the boundary.
   task automatic test_pend_change();
      logic exp_div, exp_en;
      bus.cfg_valid = 1'b1; bus.cfg_div = 5'd4;   // accepted at cnt = 0
      tick();
      bus.cfg_valid = 1'b0;
      n_tests++; if (bus.busy !== 1'b1)      begin n_fail++; $display("FAIL pend_busy_1: got %b expected 1", bus.busy); end
      n_tests++; if (bus.cfg_ready !== 1'b0) begin n_fail++; $display("FAIL pend_ready: got %b expected 0", bus.cfg_ready); end
      n_tests++; if (bus.cur_div !== 5'd3)   begin n_fail++; $display("FAIL pend_old_div: got %0d expected 3", bus.cur_div); end
      n_tests++; if (bus.clk_div !== 1'b1)   begin n_fail++; $display("FAIL pend_clk_div_1: got %b expected 1", bus.clk_div); end
      // A request while not ready must be ignored.
      bus.cfg_valid = 1'b1; bus.cfg_div = 5'd7;
      tick();
      bus.cfg_valid = 1'b0;
      n_tests++; if (bus.busy !== 1'b1)    begin n_fail++; $display("FAIL pend_busy_2: got %b expected 1", bus.busy); end
      n_tests++; if (bus.clk_div !== 1'b0) begin n_fail++; $display("FAIL pend_clk_div_2: got %b expected 0", bus.clk_div); end
      n_tests++; if (bus.clk_en !== 1'b1)  begin n_fail++; $display("FAIL pend_clk_en_2: got %b expected 1", bus.clk_en); end
      tick();
      n_tests++; if (bus.busy !== 1'b0)    begin n_fail++; $display("FAIL pend_commit_busy: got %b expected 0", bus.busy); end
      n_tests++; if (bus.cur_div !== 5'd4) begin n_fail++; $display("FAIL pend_commit_div: got %0d expected 4", bus.cur_div); end
      for (int i = 0; i < 8; i++) begin
         exp_div = ((i % 4) < 2);
         exp_en  = ((i % 4) == 3);
         n_tests++; if (bus.clk_div !== exp_div) begin n_fail++; $display("FAIL div4_clk_div cycle %0d: got %b expected %b", i, bus.clk_div, exp_div); end
         n_tests++; if (bus.clk_en !== exp_en)   begin n_fail++; $display("FAIL div4_clk_en cycle %0d: got %b expected %b", i, bus.clk_en, exp_en); end
         tick();
      end
   endtask

   task automatic test_err();
      bus.cfg_valid = 1'b1; bus.cfg_div = 5'd0;   // N=4, cnt = 0
      tick();
      bus.cfg_valid = 1'b0;
      n_tests++; if (bus.err !== 1'b1)       begin n_fail++; $display("FAIL err_set: got %b expected 1", bus.err); end
      n_tests++; if (bus.cur_div !== 5'd4)   begin n_fail++; $display("FAIL err_cur_div: got %0d expected 4", bus.cur_div); end
      n_tests++; if (bus.busy !== 1'b0)      begin n_fail++; $display("FAIL err_busy: got %b expected 0", bus.busy); end
      n_tests++; if (bus.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL err_ready: got %b expected 1", bus.cfg_ready); end
      n_tests++; if (bus.clk_div !== 1'b1)   begin n_fail++; $display("FAIL err_clk_div: got %b expected 1", bus.clk_div); end
      tick();                                      // cnt = 2
      n_tests++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", bus.err); end
      bus.cfg_valid = 1'b1; bus.err_clr = 1'b1;    // clear and new error together
      tick();                                      // cnt = 3
      bus.cfg_valid = 1'b0;
      n_tests++; if (bus.err !== 1'b1)    begin n_fail++; $display("FAIL err_clr_collide: got %b expected 1", bus.err); end
      n_tests++; if (bus.clk_en !== 1'b1) begin n_fail++; $display("FAIL err_clk_en: got %b expected 1", bus.clk_en); end
      tick();                                      // err_clr alone, cnt = 0
      bus.err_clr = 1'b0;
      n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b expected 0", bus.err); end
      bus.en = 1'b0;
      tick();
      n_tests++; if (bus.clk_div !== 1'b0) begin n_fail++; $display("FAIL stop_clk_div: got %b expected 0", bus.clk_div); end
      n_tests++; if (bus.clk_en !== 1'b0)  begin n_fail++; $display("FAIL stop_clk_en: got %b expected 0", bus.clk_en); end
      n_tests++; if (bus.cur_div !== 5'd4) begin n_fail++; $display("FAIL stop_cur_div: got %0d expected 4", bus.cur_div); end
   endtask

   task automatic test_stop_in_pend();
      logic exp_div, exp_en;
      bus.en = 1'b1;
      tick();                                      // RUN, cnt = 0
      bus.cfg_valid = 1'b1; bus.cfg_div = 5'd6;
      tick();
      bus.cfg_valid = 1'b0;
      n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL stoppend_busy: got %b expected 1", bus.busy); end
      bus.en = 1'b0;
      tick();
      n_tests++; if (bus.clk_div !== 1'b0)   begin n_fail++; $display("FAIL stoppend_clk_div: got %b expected 0", bus.clk_div); end
      n_tests++; if (bus.clk_en !== 1'b0)    begin n_fail++; $display("FAIL stoppend_clk_en: got %b expected 0", bus.clk_en); end
      n_tests++; if (bus.busy !== 1'b0)      begin n_fail++; $display("FAIL stoppend_busy_off: got %b expected 0", bus.busy); end
      n_tests++; if (bus.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL stoppend_ready: got %b expected 1", bus.cfg_ready); end
      n_tests++; if (bus.cur_div !== 5'd6)   begin n_fail++; $display("FAIL stoppend_cur_div: got %0d expected 6", bus.cur_div); end
      tick();
      n_tests++; if (bus.clk_div !== 1'b0) begin n_fail++; $display("FAIL stoppend_hold: got %b expected 0", bus.clk_div); end
      bus.en = 1'b1;
      tick();
      for (int i = 0; i < 6; i++) begin
         exp_div = (i < 3);
         exp_en  = (i == 5);
         n_tests++; if (bus.clk_div !== exp_div) begin n_fail++; $display("FAIL div6_clk_div cycle %0d: got %b expected %b", i, bus.clk_div, exp_div); end
         n_tests++; if (bus.clk_en !== exp_en)   begin n_fail++; $display("FAIL div6_clk_en cycle %0d: got %b expected %b", i, bus.clk_en, exp_en); end
         tick();
      end
   endtask

   task automatic test_div1_and_async_reset();
      bus.en = 1'b0;
      tick();
      bus.cfg_valid = 1'b1; bus.cfg_div = 5'd1;   // load while stopped
      tick();
      bus.cfg_valid = 1'b0;
      n_tests++; if (bus.cur_div !== 5'd1) begin n_fail++; $display("FAIL div1_load: got %0d expected 1", bus.cur_div); end
      n_tests++; if (bus.clk_div !== 1'b0) begin n_fail++; $display("FAIL div1_stopped: got %b expected 0", bus.clk_div); end
      bus.en = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         n_tests++; if (bus.clk_div !== 1'b1) begin n_fail++; $display("FAIL div1_clk_div cycle %0d: got %b expected 1", i, bus.clk_div); end
         n_tests++; if (bus.clk_en !== 1'b1)  begin n_fail++; $display("FAIL div1_clk_en cycle %0d: got %b expected 1", i, bus.clk_en); end
         tick();
      end
      bus.cfg_valid = 1'b1; bus.cfg_div = 5'd0;
      tick();
      bus.cfg_valid = 1'b0;
      n_tests++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL div1_err: got %b expected 1", bus.err); end
      // Reset between clock edges must act at once.
      rst = 1'b0;
      #2;
      n_tests++; if (bus.clk_div !== 1'b0)   begin n_fail++; $display("FAIL async_clk_div: got %b expected 0", bus.clk_div); end
      n_tests++; if (bus.clk_en !== 1'b0)    begin n_fail++; $display("FAIL async_clk_en: got %b expected 0", bus.clk_en); end
      n_tests++; if (bus.cur_div !== 5'd3)   begin n_fail++; $display("FAIL async_cur_div: got %0d expected 3", bus.cur_div); end
      n_tests++; if (bus.err !== 1'b0)       begin n_fail++; $display("FAIL async_err: got %b expected 0", bus.err); end
      n_tests++; if (bus.busy !== 1'b0)      begin n_fail++; $display("FAIL async_busy: got %b expected 0", bus.busy); end
      n_tests++; if (bus.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL async_ready: got %b expected 1", bus.cfg_ready); end
      bus.en = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   // Reset in PEND drops the pending ratio.
   task automatic test_reset_in_pend();
      logic exp_div, exp_en;
      bus.en = 1'b1;
      tick();                                      // RUN N=3, cnt = 0
      bus.cfg_valid = 1'b1; bus.cfg_div = 5'd5;
      tick();
      bus.cfg_valid = 1'b0;
      n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rstpend_busy: got %b expected 1", bus.busy); end
      rst = 1'b0;
      #2;
      n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstpend_busy_off: got %b expected 0", bus.busy); end
      tick();
      rst = 1'b1;
      tick();                                      // STOP -> RUN, cnt = 0
      for (int i = 0; i < 6; i++) begin
         exp_div = ((i % 3) != 2);
         exp_en  = ((i % 3) == 2);
         n_tests++; if (bus.clk_div !== exp_div) begin n_fail++; $display("FAIL rstpend_clk_div cycle %0d: got %b expected %b", i, bus.clk_div, exp_div); end
         n_tests++; if (bus.clk_en !== exp_en)   begin n_fail++; $display("FAIL rstpend_clk_en cycle %0d: got %b expected %b", i, bus.clk_en, exp_en); end
         n_tests++; if (bus.cur_div !== 5'd3)    begin n_fail++; $display("FAIL rstpend_cur_div cycle %0d: got %0d expected 3", i, bus.cur_div); end
         tick();
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_default_run();
      test_direct_change();
      test_pend_change();
      test_err();
      test_stop_in_pend();
      test_div1_and_async_reset();
      test_reset_in_pend();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
